// File: rtl/imm_field_encoder.sv
// Packs a 64-bit immediate into its LEGv8 field and merges it into an instruction template; latency 2 cycles.
// Backpressure: valid/ready, in_ready = !S1 valid | S2 can load; optional error counter under IMM_ERR_CNT_EN.
// Full-rate pipeline: one result per cycle, outputs held stable while out_valid & !out_ready.
module imm_field_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [63:0] in_value,
    input  logic [31:0] in_template,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_range,
    output logic        out_align
`ifdef IMM_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [1:0] FMT_ALU = 2'b00;
    localparam logic [1:0] FMT_DT  = 2'b01;
    localparam logic [1:0] FMT_B   = 2'b10;
    localparam logic [1:0] FMT_CB  = 2'b11;

    logic        s1_vld_q,  s1_vld_d;
    logic [1:0]  s1_fmt_q,  s1_fmt_d;
    logic [63:0] s1_value_q, s1_value_d;
    logic [31:0] s1_tmpl_q, s1_tmpl_d;

    logic        s2_vld_q,   s2_vld_d;
    logic [31:0] s2_insn_q,  s2_insn_d;
    logic        s2_range_q, s2_range_d;
    logic        s2_align_q, s2_align_d;

    logic        s2_load;
    logic        in_hs;
    logic [31:0] field_mask;
    logic [31:0] field_bits;
    logic        enc_range;
    logic        enc_align;
    logic [31:0] enc_insn;

    assign s2_load  = !s2_vld_q || out_ready;
    assign in_ready = !s1_vld_q || s2_load;
    assign in_hs    = in_valid && in_ready;

    // Field placement and representability check on the S1 registered operand.
    always_comb begin
        field_mask = 32'h0;
        field_bits = 32'h0;
        enc_range  = 1'b0;
        enc_align  = 1'b0;
        case (s1_fmt_q)
            FMT_ALU: begin
                field_mask = 32'h003F_FC00;
                field_bits = {10'b0, s1_value_q[11:0], 10'b0};
                enc_range  = |s1_value_q[63:12];
            end
            FMT_DT: begin
                field_mask = 32'h001F_F000;
                field_bits = {11'b0, s1_value_q[8:0], 12'b0};
                enc_range  = !((&s1_value_q[63:8]) || !(|s1_value_q[63:8]));
            end
            FMT_B: begin
                field_mask = 32'h03FF_FFFF;
                field_bits = {6'b0, s1_value_q[27:2]};
                enc_range  = !((&s1_value_q[63:27]) || !(|s1_value_q[63:27]));
                enc_align  = |s1_value_q[1:0];
            end
            FMT_CB: begin
                field_mask = 32'h00FF_FFE0;
                field_bits = {8'b0, s1_value_q[20:2], 5'b0};
                enc_range  = !((&s1_value_q[63:20]) || !(|s1_value_q[63:20]));
                enc_align  = |s1_value_q[1:0];
            end
            default: ;
        endcase
        enc_insn = (s1_tmpl_q & ~field_mask) | (field_bits & field_mask);
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_fmt_d   = s1_fmt_q;
        s1_value_d = s1_value_q;
        s1_tmpl_d  = s1_tmpl_q;
        if (in_hs) begin
            s1_vld_d   = 1'b1;
            s1_fmt_d   = in_fmt;
            s1_value_d = in_value;
            s1_tmpl_d  = in_template;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end
    end

    always_comb begin
        s2_vld_d   = s2_vld_q;
        s2_insn_d  = s2_insn_q;
        s2_range_d = s2_range_q;
        s2_align_d = s2_align_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_insn_d  = enc_insn;
                s2_range_d = enc_range;
                s2_align_d = enc_align;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_fmt_q   <= 2'b0;
            s1_value_q <= 64'h0;
            s1_tmpl_q  <= 32'h0;
            s2_vld_q   <= 1'b0;
            s2_insn_q  <= 32'h0;
            s2_range_q <= 1'b0;
            s2_align_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_value_q <= s1_value_d;
            s1_tmpl_q  <= s1_tmpl_d;
            s2_vld_q   <= s2_vld_d;
            s2_insn_q  <= s2_insn_d;
            s2_range_q <= s2_range_d;
            s2_align_q <= s2_align_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_insn  = s2_insn_q;
    assign out_range = s2_range_q;
    assign out_align = s2_align_q;

`ifdef IMM_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_vld_q && out_ready && (s2_range_q || s2_align_q) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 16'h0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
